// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-and-add unsigned multiplier, one multiplier
// bit retired per clock, start/busy/product_valid handshake.
// Optional build macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (b==0 completes straight from IDLE).
module seq_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid,
    output logic                 ovf
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic [PW-1:0]      product_q, product_d;
    logic               product_valid_q, product_valid_d;
    logic               ovf_q, ovf_d;

    logic [PW-1:0]      addend_c;
    logic [PW-1:0]      sum_c;
    logic               last_c;

    // Datapath for the current iteration and the last-iteration decision
    always_comb begin
        addend_c = mplr_q[0] ? mcand_q : '0;
        sum_c    = acc_q + addend_c;
        last_c   = (count_q == CNT_W'(WIDTH - 1));
`ifdef SEQ_MUL_EARLY_TERM_EN
        last_c   = last_c || ((mplr_q >> 1) == '0);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef SEQ_MUL_EARLY_TERM_EN
                    state_d = (b == '0) ? S_DONE : S_BUSY;
`else
                    state_d = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                if (last_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        mcand_d         = mcand_q;
        mplr_d          = mplr_q;
        acc_d           = acc_q;
        count_d         = count_q;
        product_d       = product_q;
        ovf_d           = ovf_q;
        product_valid_d = 1'b0;
        busy_d          = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, a};
                    mplr_d  = b;
                    acc_d   = '0;
                    count_d = '0;
`ifdef SEQ_MUL_EARLY_TERM_EN
                    if (b == '0) begin
                        product_d       = '0;
                        ovf_d           = 1'b0;
                        product_valid_d = 1'b1;
                    end
`endif
                end
            end
            S_BUSY: begin
                acc_d   = sum_c;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                count_d = count_q + CNT_W'(1);
                if (last_c) begin
                    product_d       = sum_c;
                    ovf_d           = |sum_c[PW-1:WIDTH];
                    product_valid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q         <= '0;
            mplr_q          <= '0;
            acc_q           <= '0;
            count_q         <= '0;
            busy_q          <= 1'b0;
            product_q       <= '0;
            product_valid_q <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            mcand_q         <= mcand_d;
            mplr_q          <= mplr_d;
            acc_q           <= acc_d;
            count_q         <= count_d;
            busy_q          <= busy_d;
            product_q       <= product_d;
            product_valid_q <= product_valid_d;
            ovf_q           <= ovf_d;
        end
    end

    assign busy          = busy_q;
    assign product       = product_q;
    assign product_valid = product_valid_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vector table plus
// hand-written sequences for ignored starts, mid-operation reset and a
// short random regression.
module tb_seq_multiplier;

    localparam int unsigned WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [WIDTH-1:0]     a = '0;
    logic [WIDTH-1:0]     b = '0;
    logic                 busy;
    logic [2*WIDTH-1:0]   product;
    logic                 product_valid;
    logic                 ovf;

    int n_vec = 0;
    int n_err = 0;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .product       (product),
        .product_valid (product_valid),
        .ovf           (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_product;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected completion latency (edges after the accepting edge)
    function automatic int exp_lat(input logic [15:0] bv);
`ifdef SEQ_MUL_EARLY_TERM_EN
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (bv[i]) n = i + 1;
        return n;
`else
        return (bv == 16'h0) ? 16 : 16;
`endif
    endfunction

    // Launch one operation and check latency, product, ovf and the return to idle
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] ep, input logic eo, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom_range(0, 16'hFFFF); b = $urandom_range(0, 16'hFFFF);
        check({tag, " busy_after_start"}, busy, 1);
        lat = 0;
        seen = product_valid;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            seen = product_valid;
        end
        check({tag, " valid_seen"}, seen, 1);
        check({tag, " latency"}, lat, exp_lat(bv));
        check({tag, " product"}, product, ep);
        check({tag, " ovf"}, ovf, eo);
        @(posedge clk);
        #1;
        check({tag, " valid_pulse_end"}, product_valid, 0);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " product_held"}, product, ep);
    endtask

    vec_t vecs[10];

    initial begin
        int valids;
        logic [15:0] ra, rb;
        logic [31:0] rp;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1};
        vecs[2] = '{16'h0100, 16'h00FF, 32'h0000_FF00, 1'b0};
        vecs[3] = '{16'h1234, 16'h0001, 32'h0000_1234, 1'b0};
        vecs[4] = '{16'h5A5A, 16'h0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{16'h0002, 16'h8000, 32'h0001_0000, 1'b1};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0};
        vecs[7] = '{16'hFFFF, 16'h0002, 32'h0001_FFFE, 1'b1};
        vecs[8] = '{16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0};
        vecs[9] = '{16'h0100, 16'h0100, 32'h0001_0000, 1'b1};

        // Reset state
        #12;
        check("reset busy", busy, 0);
        check("reset product", product, 0);
        check("reset valid", product_valid, 0);
        check("reset ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp_product, vecs[i].exp_ovf,
                  $sformatf("vec%0d", i));
        end

        // Starts while busy and in the DONE cycle are ignored
        @(negedge clk);
        start = 1'b1; a = 16'd7; b = 16'd9;
        @(posedge clk);                       // edge k
        #1;
        start = 1'b0;
        valids = 0;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            start = (e == 5 || e == 17);      // sampled at edge k+5 and edge k+17 (DONE)
            a = 16'd2; b = 16'd2;
            @(posedge clk);
            #1;
            if (product_valid) valids++;
        end
        start = 1'b0;
        check("ignore valid_count", valids, 1);
        check("ignore product", product, 63);
        check("ignore busy_after_done", busy, 0);
        do_op(16'd2, 16'd2, 32'd4, 1'b0, "after_ignore");

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1; a = 16'd100; b = 16'hC8C8;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);            // edge k+8
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst product", product, 0);
        check("midrst busy", busy, 0);
        check("midrst valid", product_valid, 0);
        check("midrst ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        valids = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (product_valid || busy) valids++;
        end
        check("midrst no_activity", valids, 0);
        do_op(16'd12, 16'd12, 32'd144, 1'b0, "after_reset");

        // Short random regression with random gaps
        for (int r = 0; r < 250; r++) begin
            ra = 16'($urandom_range(0, 16'hFFFF));
            rb = 16'($urandom_range(0, 16'hFFFF));
            if (r % 8 == 0) rb = 16'(1 << (r % 16));
            rp = 32'(ra) * 32'(rb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(ra, rb, rp, (rp > 32'h0000_FFFF), $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
